// File: rtl/matvec_job_scheduler.sv
// Job-queue front end for the matrix-vector core: buffers {rows, cols} jobs in order
// and walks each one through CLEAR -> CAL -> READ -> DONE, driving the core strobes.
module matvec_job_scheduler #(
    parameter int SIZE_W = 8,
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [SIZE_W-1:0]         job_rows,
    input  logic [SIZE_W-1:0]         job_cols,
    input  logic                      abort,
    output logic                      core_clear,
    output logic                      core_start,
    output logic [SIZE_W-1:0]         core_rows,
    output logic [SIZE_W-1:0]         core_cols,
    output logic                      read,
    output logic                      busy,
    output logic                      done_pulse,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [CNT_W-1:0]          jobs_done
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CAL,
        S_READ,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [SIZE_W:0]     phase_q;
    logic [SIZE_W-1:0]   rows_q, cols_q;
    logic [CNT_W-1:0]    jobs_done_q;
    logic [SIZE_W-1:0]   mem_rows [QDEPTH];
    logic [SIZE_W-1:0]   mem_cols [QDEPTH];

    logic push, pop, cal_last, read_last;

    always_comb begin
        job_ready = (count_q < CW'(QDEPTH));
        push      = job_valid && job_ready && !abort;
        pop       = (state_q == S_IDLE) && (count_q != '0) && !abort;
        count_d   = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        // Sum is one bit wider than the size fields so 255+255 does not wrap.
        cal_last  = (phase_q == ({1'b0, rows_q} + {1'b0, cols_q}));
        read_last = (phase_q == {1'b0, cols_q});
    end

    // NOTE: queue storage has no reset; an entry is only read after it was written,
    // and the occupancy count alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rows[wr_ptr_q] <= job_rows;
            mem_cols[wr_ptr_q] <= job_cols;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            phase_q     <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            jobs_done_q <= '0;
        end else if (abort) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            phase_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        rows_q  <= mem_rows[rd_ptr_q];
                        cols_q  <= mem_cols[rd_ptr_q];
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    phase_q <= '0;
                    state_q <= S_CAL;
                end
                S_CAL: begin
                    if (cal_last) begin
                        phase_q <= '0;
                        state_q <= S_READ;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_READ: begin
                    if (read_last) begin
                        phase_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_DONE: begin
                    jobs_done_q <= jobs_done_q + 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the registered state and phase counter.
    assign core_clear = (state_q == S_CLEAR);
    assign core_start = (state_q == S_CAL) && (phase_q == '0);
    assign read       = (state_q == S_READ);
    assign done_pulse = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign core_rows  = rows_q;
    assign core_cols  = cols_q;
    assign q_count    = count_q;
    assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_matvec_job_scheduler.sv
// Bench for matvec_job_scheduler: directed scenarios plus random traffic, every cycle
// compared against a job-queue / phase-trace model of the scheduler.
module tb_matvec_job_scheduler;

    localparam int SIZE_W = 8;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = 16;

    typedef enum int {PH_CLEAR, PH_CAL_START, PH_CAL, PH_READ, PH_DONE} ph_t;
    typedef struct {int rows; int cols;} job_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic job_valid = 1'b0;
    logic abort = 1'b0;
    logic [SIZE_W-1:0] job_rows = '0;
    logic [SIZE_W-1:0] job_cols = '0;
    logic job_ready, core_clear, core_start, read, busy, done_pulse;
    logic [SIZE_W-1:0] core_rows, core_cols;
    logic [$clog2(QDEPTH):0] q_count;
    logic [CNT_W-1:0] jobs_done;

    matvec_job_scheduler #(.SIZE_W(SIZE_W), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_rows(job_rows), .job_cols(job_cols), .abort(abort),
        .core_clear(core_clear), .core_start(core_start),
        .core_rows(core_rows), .core_cols(core_cols), .read(read), .busy(busy),
        .done_pulse(done_pulse), .q_count(q_count), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: pending jobs plus the expanded per-cycle phase trace of the active job.
    job_t mq[$];
    ph_t  trace[$];
    int   m_rows = 0, m_cols = 0, m_done = 0;
    bit   last_push = 0;

    int cyc = 0;
    bit rec = 0;
    int t_clear, t_start, t_read, t_done, n_read, n_busy, max_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_ph();
        return (trace.size() != 0) ? int'(trace[0]) : -1;
    endfunction

    task automatic model_update(input bit v, input int r, input int c, input bit ab, input bit rn);
        bit   push_ok;
        job_t j;
        if (!rn) begin
            mq.delete(); trace.delete();
            m_rows = 0; m_cols = 0; m_done = 0; last_push = 0;
        end else if (ab) begin
            mq.delete(); trace.delete(); last_push = 0;
        end else begin
            push_ok = v && (mq.size() < QDEPTH);
            if (trace.size() == 0) begin
                if (mq.size() > 0) begin
                    j = mq.pop_front();
                    m_rows = j.rows; m_cols = j.cols;
                    trace.push_back(PH_CLEAR);
                    trace.push_back(PH_CAL_START);
                    repeat (j.rows + j.cols) trace.push_back(PH_CAL);
                    repeat (j.cols + 1) trace.push_back(PH_READ);
                    trace.push_back(PH_DONE);
                end
            end else begin
                if (trace[0] == PH_DONE) m_done = (m_done + 1) % (1 << CNT_W);
                void'(trace.pop_front());
            end
            if (push_ok) begin
                j.rows = r; j.cols = c;
                mq.push_back(j);
            end
            last_push = push_ok;
        end
    endtask

    // One clock cycle: compare the current cycle's outputs, drive inputs, advance the model.
    task automatic step(input bit v, input int r, input int c, input bit ab, input bit rn);
        int ph;
        ph = cur_ph();
        check("busy",       busy,       (ph != -1));
        check("core_clear", core_clear, (ph == PH_CLEAR));
        check("core_start", core_start, (ph == PH_CAL_START));
        check("read",       read,       (ph == PH_READ));
        check("done_pulse", done_pulse, (ph == PH_DONE));
        check("q_count",    q_count,    mq.size());
        check("job_ready",  job_ready,  (mq.size() < QDEPTH));
        check("core_rows",  core_rows,  m_rows);
        check("core_cols",  core_cols,  m_cols);
        check("jobs_done",  jobs_done,  m_done);
        if (rec) begin
            if (core_clear && t_clear < 0) t_clear = cyc;
            if (core_start && t_start < 0) t_start = cyc;
            if (read && t_read < 0)        t_read  = cyc;
            if (done_pulse && t_done < 0)  t_done  = cyc;
            if (read) n_read++;
            if (busy) n_busy++;
            if (int'(q_count) > max_q) max_q = int'(q_count);
        end
        job_valid = v; job_rows = r[SIZE_W-1:0]; job_cols = c[SIZE_W-1:0];
        abort = ab; reset = rn;
        @(posedge clk);
        model_update(v, r, c, ab, rn);
        @(negedge clk);
        cyc++;
    endtask

    task automatic rec_start();
        rec = 1; t_clear = -1; t_start = -1; t_read = -1; t_done = -1;
        n_read = 0; n_busy = 0; max_q = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (trace.size() == 0 && mq.size() == 0 && !busy && q_count == '0) break;
            step(0, 0, 0, 0, 1);
        end
        check({tag, "_drained_busy"}, busy, 0);
        check({tag, "_drained_qcount"}, q_count, 0);
    endtask

    // Holds job_valid until the job is accepted, within a cycle budget.
    task automatic push_job(input string tag, input int r, input int c);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step(1, r, c, 0, 1);
            ok = last_push;
        end
        check({tag, "_push_accepted"}, {31'd0, ok}, 1);
    endtask

    task automatic wait_phase(input int ph, input int max_cycles);
        for (int i = 0; i < max_cycles && cur_ph() != ph; i++) step(0, 0, 0, 0, 1);
        check("wait_phase_reached", cur_ph(), ph);
    endtask

    initial begin
        int t0, jd;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // 1: single job 2x3, timing relative to the push cycle
        rec_start();
        t0 = cyc;
        step(1, 2, 3, 0, 1);
        drain("t1", 100);
        check("t1_clear_cycle", t_clear - t0, 2);
        check("t1_start_cycle", t_start - t0, 3);
        check("t1_read_cycle",  t_read - t0, 9);
        check("t1_done_cycle",  t_done - t0, 13);
        check("t1_read_len",    n_read, 4);
        check("t1_busy_len",    n_busy, 12);
        check("t1_jobs_done",   jobs_done, 1);

        // 2: four pushes while idle, then five while busy (queue fills, 5th held)
        rec_start();
        jd = int'(jobs_done);
        for (int i = 0; i < 4; i++) step(1, i + 1, i + 2, 0, 1);
        for (int i = 0; i < 5; i++) push_job("t2", 3 + i, 1 + i);
        drain("t2", 500);
        check("t2_max_qcount", max_q, 4);
        check("t2_jobs_added", int'(jobs_done) - jd, 9);

        // 3: zero-size job
        rec_start();
        step(1, 0, 0, 0, 1);
        drain("t3", 50);
        check("t3_cal_len",  t_read - t_start, 1);
        check("t3_read_len", n_read, 1);
        check("t3_done_after_read", t_done - t_read, 1);

        // 4: maximum-size job, no 8-bit wrap of rows+cols
        rec_start();
        step(1, 255, 255, 0, 1);
        drain("t4", 1000);
        check("t4_cal_len",  t_read - t_start, 511);
        check("t4_read_len", n_read, 256);
        check("t4_busy_len", n_busy, 769);

        // 5: abort mid-CAL with two jobs queued; a push in the abort cycle is dropped
        step(1, 5, 5, 0, 1);
        push_job("t5a", 3, 3);
        push_job("t5b", 2, 2);
        wait_phase(PH_CAL, 50);
        idle(2);
        jd = int'(jobs_done);
        check("t5_qcount_before", q_count, 2);
        step(1, 7, 7, 1, 1);
        rec_start();
        check("t5_busy_after",   busy, 0);
        check("t5_qcount_after", q_count, 0);
        idle(10);
        check("t5_jobs_done", jobs_done, jd);
        check("t5_no_read",   n_read, 0);
        check("t5_no_done",   (t_done < 0), 1);

        // 6: reset pulse during READ, then a fresh job
        step(1, 4, 4, 0, 1);
        wait_phase(PH_READ, 50);
        step(0, 0, 0, 0, 0);
        check("t6_jobs_done_reset", jobs_done, 0);
        check("t6_rows_reset", core_rows, 0);
        step(1, 1, 2, 0, 1);
        drain("t6", 50);
        check("t6_jobs_done_after", jobs_done, 1);

        // abort in IDLE with an empty queue is a no-op
        step(0, 0, 0, 1, 1);
        check("idle_abort_rows", core_rows, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 149) != 0);
        end
        drain("rand", 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
